fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning program counter and memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning memory data and operand width.
REQ-003 SHALL have parameter RESET_VECTOR, default 16'hF000, meaning the first fetch address after reset.
REQ-004 SHALL have port clk  input  1  system clock, all state updated on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port mem_addr_o  output  ADDR_WIDTH  fetch address, equal to pc_o.
REQ-007 SHALL have port mem_rd_o  output  1  read request, held high until acknowledged.
REQ-008 SHALL have port mem_ack_i  input  1  read acknowledge; mem_rdata_i valid in the same cycle.
REQ-009 SHALL have port mem_rdata_i  input  DATA_WIDTH  read data.
REQ-010 SHALL have port instr_len_i  input  2  instruction length in bytes, combinational decode of opcode_o.
REQ-011 SHALL have ports opcode_o, operand_lo_o, operand_hi_o  output  DATA_WIDTH each  captured instruction bytes.
REQ-012 SHALL have port pc_o  output  ADDR_WIDTH  program counter.
REQ-013 SHALL have port instr_valid_o  output  1  complete instruction presented to the execute stage.
REQ-014 SHALL have port instr_ready_i  input  1  execute stage accepts the instruction.
REQ-015 SHALL have ports jump_i  input  1  and jump_cond_i  input  2  (00 always, 01 Z, 10 NZ, 11 N), sampled on accept.
REQ-016 SHALL have ports flag_zero_i, flag_negative_i  input  1 each  current ALU flags.
REQ-017 SHALL have port halt_i  input  1  accepted instruction is HLT, sampled on accept.
REQ-018 SHALL have port halted_o  output  1  sequencer stopped.

Function
REQ-019 SHALL implement states FETCH_OP, DECODE, FETCH_LO, FETCH_HI, ISSUE, HALTED.
REQ-020 SHALL assert mem_rd_o only in FETCH_OP, FETCH_LO, FETCH_HI, holding it and mem_addr_o stable until mem_ack_i.
REQ-021 SHALL on each mem_ack_i in a FETCH state capture mem_rdata_i into opcode_o / operand_lo_o / operand_hi_o respectively and increment pc_o by 1, wrapping FFFF->0000.
REQ-022 SHALL ignore mem_ack_i outside FETCH states.
REQ-023 SHALL move FETCH_OP->DECODE on ack; DECODE lasts exactly one cycle and samples instr_len_i.
REQ-024 SHALL from DECODE go to ISSUE if len is 1 or 0 (0 treated as 1), else FETCH_LO.
REQ-025 SHALL from FETCH_LO on ack go to FETCH_HI if len is 3, else ISSUE; FETCH_HI on ack goes to ISSUE.
REQ-026 SHALL clear operand_lo_o and operand_hi_o to 0 on entry to DECODE so unfetched bytes read as 0.
REQ-027 SHALL assert instr_valid_o only in ISSUE, holding opcode/operands stable until instr_ready_i.
REQ-028 SHALL on accept (ISSUE and instr_ready_i) evaluate take = jump_i and condition(jump_cond_i, flags) using flag values in the accept cycle.
REQ-029 SHALL on accept with take=1 load pc_o <= {operand_hi_o, operand_lo_o}; with take=0 leave pc_o pointing at the next sequential byte.
REQ-030 SHALL on accept go to HALTED if halt_i, else FETCH_OP; halt_i takes priority over jump_i (pc_o unchanged).
REQ-031 SHALL in HALTED hold pc_o and all outputs, deassert mem_rd_o and instr_valid_o, assert halted_o, until reset.
REQ-032 SHALL have fetch-to-issue latency of (number of bytes) ack cycles plus 1 DECODE cycle plus 1 cycle to enter ISSUE.

Reset
REQ-033 SHALL on reset set pc_o=RESET_VECTOR, state FETCH_OP, opcode_o/operand_lo_o/operand_hi_o=0, instr_valid_o=0, halted_o=0; mem_rd_o asserts the cycle after reset deasserts.
REQ-034 SHALL let reset in any state, including mid-fetch with mem_rd_o high or HALTED, override all other inputs that cycle.

Verification
REQ-035 SHALL cover: 1-byte opcode at F000, ack immediate, len=1 -> instr_valid_o with opcode, operands 00, pc_o=F001.
REQ-036 SHALL cover: 3-byte JZ at F004 bytes (op,09,F0), flag_zero_i=1, jump_cond_i=01 -> pc_o F007 before accept, F009 after.
REQ-037 SHALL cover: same JZ with flag_zero_i=0 -> pc_o remains F007, next fetch at F007.
REQ-038 SHALL cover: mem_ack_i delayed 3 cycles and instr_ready_i delayed 2 cycles -> mem_addr_o and instr bytes stable throughout, no extra pc increment.
REQ-039 SHALL cover: halt_i with jump_i=1 on accept -> HALTED, halted_o=1, pc_o unchanged, no mem_rd_o for 20 cycles; reset -> pc_o=F000, fetch resumes.
REQ-040 SHALL cover: pc_o=FFFF 2-byte fetch -> operand read at 0000, pc_o=0001 at ISSUE.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory read bus and instruction issue channel of the fetch sequencer
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_rd_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic [1:0]            instr_len_i;
    logic [DATA_WIDTH-1:0] opcode_o;
    logic [DATA_WIDTH-1:0] operand_lo_o;
    logic [DATA_WIDTH-1:0] operand_hi_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic                  jump_i;
    logic [1:0]            jump_cond_i;
    logic                  halt_i;

    modport master (
        output mem_addr_o, mem_rd_o,
        input  mem_ack_i, mem_rdata_i,
        input  instr_len_i,
        output opcode_o, operand_lo_o, operand_hi_o, instr_valid_o,
        input  instr_ready_i, jump_i, jump_cond_i, halt_i
    );

    modport slave (
        input  mem_addr_o, mem_rd_o,
        output mem_ack_i, mem_rdata_i,
        output instr_len_i,
        input  opcode_o, operand_lo_o, operand_hi_o, instr_valid_o,
        output instr_ready_i, jump_i, jump_cond_i, halt_i
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - byte-serial instruction fetch, decode-length and issue sequencer
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(16'hF000)
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_sequencer_if.master     bus,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic                  flag_zero_i,
    input  logic                  flag_negative_i,
    output logic                  halted_o
);
    typedef enum logic [2:0] {
        FETCH_OP,
        DECODE,
        FETCH_LO,
        FETCH_HI,
        ISSUE,
        HALTED
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_opcode;
    logic [DATA_WIDTH-1:0] r_operand_lo;
    logic [DATA_WIDTH-1:0] r_operand_hi;
    logic                  r_len_three;

    logic                  w_in_fetch;
    logic                  w_fetch_ack;
    logic                  w_accept;
    logic                  w_cond_met;
    logic                  w_take;
    logic [ADDR_WIDTH-1:0] w_jump_target;

    assign w_in_fetch    = (r_state == FETCH_OP) || (r_state == FETCH_LO) || (r_state == FETCH_HI);
    assign w_fetch_ack   = w_in_fetch && bus.mem_ack_i;
    assign w_accept      = (r_state == ISSUE) && bus.instr_ready_i;
    assign w_jump_target = ADDR_WIDTH'({r_operand_hi, r_operand_lo});

    always_comb begin
        w_cond_met = 1'b1;
        case (bus.jump_cond_i)
            2'b00:   w_cond_met = 1'b1;
            2'b01:   w_cond_met = flag_zero_i;
            2'b10:   w_cond_met = !flag_zero_i;
            default: w_cond_met = flag_negative_i;
        endcase
    end

    assign w_take = bus.jump_i && w_cond_met;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH_OP;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH_OP: begin
                if (bus.mem_ack_i) begin
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                // A zero length decode is treated as a single-byte instruction.
                if (bus.instr_len_i <= 2'd1) begin
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (bus.mem_ack_i) begin
                    w_next_state = r_len_three ? FETCH_HI : ISSUE;
                end
            end
            FETCH_HI: begin
                if (bus.mem_ack_i) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready_i) begin
                    w_next_state = bus.halt_i ? HALTED : FETCH_OP;
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = FETCH_OP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_VECTOR;
            r_opcode     <= '0;
            r_operand_lo <= '0;
            r_operand_hi <= '0;
            r_len_three  <= 1'b0;
        end else begin
            if (w_fetch_ack) begin
                r_pc <= r_pc + ADDR_WIDTH'(1);
            end
            case (r_state)
                FETCH_OP: begin
                    // Operands are zeroed on the way into DECODE so unfetched bytes read as 0.
                    if (bus.mem_ack_i) begin
                        r_opcode     <= bus.mem_rdata_i;
                        r_operand_lo <= '0;
                        r_operand_hi <= '0;
                    end
                end
                DECODE: begin
                    r_len_three <= (bus.instr_len_i == 2'd3);
                end
                FETCH_LO: begin
                    if (bus.mem_ack_i) begin
                        r_operand_lo <= bus.mem_rdata_i;
                    end
                end
                FETCH_HI: begin
                    if (bus.mem_ack_i) begin
                        r_operand_hi <= bus.mem_rdata_i;
                    end
                end
                ISSUE: begin
                    // Halt wins over a jump: the pc keeps pointing past the HLT.
                    if (w_accept && !bus.halt_i && w_take) begin
                        r_pc <= w_jump_target;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_addr_o    = r_pc;
    assign bus.mem_rd_o      = w_in_fetch && !reset;
    assign bus.opcode_o      = r_opcode;
    assign bus.operand_lo_o  = r_operand_lo;
    assign bus.operand_hi_o  = r_operand_hi;
    assign bus.instr_valid_o = (r_state == ISSUE);
    assign pc_o              = r_pc;
    assign halted_o          = (r_state == HALTED);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a delayed-ack memory model
module tb_fetch_sequencer;
    typedef struct {
        logic [15:0] addr;
        bit          is_op;
    } fetch_t;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] pc;
        int          lat;
    } issue_t;

    logic        clk;
    logic        reset;
    logic [15:0] pc_o;
    logic        flag_zero_i;
    logic        flag_negative_i;
    logic        halted_o;

    fetch_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    fetch_sequencer #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (8),
        .RESET_VECTOR(16'hF000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.master),
        .pc_o           (pc_o),
        .flag_zero_i    (flag_zero_i),
        .flag_negative_i(flag_negative_i),
        .halted_o       (halted_o)
    );

    // Bench opcode decode: length lives in the low two opcode bits.
    assign bus.instr_len_i = bus.opcode_o[1:0];

    logic [7:0] mem [0:65535];
    fetch_t     fetch_q[$];
    issue_t     issue_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         op_ack_cyc = 0;
    int         ack_delay  = 0;
    bit         junk_ack   = 0;
    int         wait_cnt   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic assert_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_instr(input logic [15:0] addr, input int n, input logic [7:0] op,
                                input logic [7:0] lo, input logic [7:0] hi, input int d);
        issue_t e;
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            fetch_t f;
            a = addr + 16'(i);
            f.addr  = a;
            f.is_op = (i == 0);
            fetch_q.push_back(f);
            mem[a] = (i == 0) ? op : (i == 1) ? lo : hi;
        end
        e.op  = op;
        e.lo  = (n >= 2) ? lo : 8'h00;
        e.hi  = (n == 3) ? hi : 8'h00;
        e.pc  = addr + 16'(n);
        e.lat = 2 + (n - 1) * (1 + d);
        issue_q.push_back(e);
    endtask

    // Memory responder: acks after ack_delay waiting cycles, optionally drives stray acks when idle.
    initial begin
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 8'h00;
        forever begin
            @(negedge clk);
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = 8'h00;
            if (bus.mem_rd_o) begin
                if (fetch_q.size() == 0) begin
                    assert_eq("fetch_unexpected", fetch_q.size(), 1);
                end else begin
                    assert_eq("fetch_addr", bus.mem_addr_o, fetch_q[0].addr);
                    assert_eq("fetch_pc", pc_o, fetch_q[0].addr);
                    if (wait_cnt >= ack_delay) begin
                        bus.mem_ack_i   = 1'b1;
                        bus.mem_rdata_i = mem[fetch_q[0].addr];
                        if (fetch_q[0].is_op) op_ack_cyc = cyc;
                        void'(fetch_q.pop_front());
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
                if (junk_ack) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = 8'hEE;
                end
            end
        end
    end

    task automatic run_issue(input int rdy_dly, input bit jmp, input logic [1:0] cond,
                             input bit hlt, input bit z, input bit n);
        issue_t e;
        int     t;
        t = 0;
        @(negedge clk);
        while (!bus.instr_valid_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.instr_valid_o) begin
            assert_eq("issue_timeout", bus.instr_valid_o, 1);
            return;
        end
        if (issue_q.size() == 0) begin
            assert_eq("issue_unexpected", issue_q.size(), 1);
            return;
        end
        e = issue_q.pop_front();
        assert_eq("issue_latency", cyc - op_ack_cyc, e.lat);
        for (int i = 0; i <= rdy_dly; i++) begin
            if (i > 0) @(negedge clk);
            assert_eq("issue_valid", bus.instr_valid_o, 1);
            assert_eq("issue_opcode", bus.opcode_o, e.op);
            assert_eq("issue_lo", bus.operand_lo_o, e.lo);
            assert_eq("issue_hi", bus.operand_hi_o, e.hi);
            assert_eq("issue_pc", pc_o, e.pc);
            assert_eq("issue_no_rd", bus.mem_rd_o, 0);
        end
        bus.instr_ready_i = 1'b1;
        bus.jump_i        = jmp;
        bus.jump_cond_i   = cond;
        bus.halt_i        = hlt;
        flag_zero_i       = z;
        flag_negative_i   = n;
        @(posedge clk);
        #1;
        bus.instr_ready_i = 1'b0;
        bus.jump_i        = 1'b0;
        bus.halt_i        = 1'b0;
    endtask

    initial begin
        int rd_seen;
        reset             = 1'b1;
        bus.instr_ready_i = 1'b0;
        bus.jump_i        = 1'b0;
        bus.jump_cond_i   = 2'b00;
        bus.halt_i        = 1'b0;
        flag_zero_i       = 1'b0;
        flag_negative_i   = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        assert_eq("rst_pc", pc_o, 16'hF000);
        assert_eq("rst_valid", bus.instr_valid_o, 0);
        assert_eq("rst_halted", halted_o, 0);
        assert_eq("rst_opcode", bus.opcode_o, 0);
        assert_eq("rst_rd", bus.mem_rd_o, 0);

        expect_instr(16'hF000, 1, 8'h01, 8'h00, 8'h00, 0);
        reset = 1'b0;
        @(negedge clk);
        assert_eq("rd_after_reset", bus.mem_rd_o, 1);
        run_issue(0, 0, 2'b00, 0, 0, 0);
        assert_eq("pc_seq1", pc_o, 16'hF001);

        expect_instr(16'hF001, 2, 8'h02, 8'h55, 8'h00, 0);
        run_issue(0, 0, 2'b00, 0, 0, 0);
        expect_instr(16'hF003, 1, 8'h05, 8'h00, 8'h00, 0);
        run_issue(0, 0, 2'b00, 0, 0, 0);

        expect_instr(16'hF004, 3, 8'h13, 8'h09, 8'hF0, 0);
        run_issue(1, 1, 2'b01, 0, 1, 0);
        assert_eq("jz_taken_pc", pc_o, 16'hF009);

        expect_instr(16'hF009, 3, 8'h23, 8'h04, 8'hF0, 0);
        run_issue(0, 1, 2'b00, 0, 0, 0);
        assert_eq("jmp_always_pc", pc_o, 16'hF004);

        expect_instr(16'hF004, 3, 8'h13, 8'h09, 8'hF0, 0);
        run_issue(0, 1, 2'b01, 0, 0, 0);
        assert_eq("jz_not_taken_pc", pc_o, 16'hF007);

        ack_delay = 3;
        junk_ack  = 1;
        expect_instr(16'hF007, 2, 8'h0E, 8'h30, 8'h00, 3);
        run_issue(2, 1, 2'b11, 0, 0, 1);
        assert_eq("jn_taken_pc", pc_o, 16'h0030);
        ack_delay = 0;
        junk_ack  = 0;

        expect_instr(16'h0030, 3, 8'h1B, 8'hFF, 8'hFF, 0);
        run_issue(0, 1, 2'b10, 0, 0, 0);
        assert_eq("jnz_taken_pc", pc_o, 16'hFFFF);

        expect_instr(16'hFFFF, 2, 8'h06, 8'h77, 8'h00, 0);
        run_issue(0, 0, 2'b00, 0, 0, 0);
        assert_eq("wrap_pc", pc_o, 16'h0001);

        expect_instr(16'h0001, 1, 8'h00, 8'h00, 8'h00, 0);
        run_issue(0, 1, 2'b00, 1, 0, 0);
        assert_eq("halt_pc", pc_o, 16'h0002);
        assert_eq("halt_flag", halted_o, 1);

        junk_ack = 1;
        rd_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_rd_o || bus.instr_valid_o || !halted_o || pc_o != 16'h0002) rd_seen++;
        end
        junk_ack = 0;
        assert_eq("halt_hold_cycles", rd_seen, 0);
        assert_eq("halt_opcode_hold", bus.opcode_o, 8'h00);

        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        assert_eq("halt_reset_pc", pc_o, 16'hF000);
        assert_eq("halt_reset_flag", halted_o, 0);

        ack_delay = 4;
        expect_instr(16'hF000, 1, 8'h01, 8'h00, 8'h00, 4);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        assert_eq("midfetch_rd", bus.mem_rd_o, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        assert_eq("midfetch_reset_pc", pc_o, 16'hF000);
        assert_eq("midfetch_reset_rd", bus.mem_rd_o, 0);
        reset = 1'b0;
        run_issue(0, 0, 2'b00, 1, 0, 0);
        assert_eq("final_halt", halted_o, 1);
        assert_eq("final_pc", pc_o, 16'hF001);
        assert_eq("fetch_q_drained", fetch_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
